// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package pipe_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_add_slice.sv
// Combinational ripple-carry slice built from one-bit full adders.
module add_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_ci,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_co,
    output logic               o_c_msb
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    // Carry into the slice MSB; only the top slice's value matters for overflow.
    assign o_co    = w_c[SLICE_W];
    assign o_c_msb = w_c[SLICE_W - 1];

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor: one SLICE-bit add per stage, valid bit per
// stage, whole pipe advances together when the output is free or consumed.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be an integer multiple of STAGES");
    end

    // Skew registers keep the not-yet-added operand bits right-aligned, so each
    // stage always adds the low slice; sum slices enter at the top and shift
    // down, landing fully aligned after the last stage.
    logic             r_valid [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];
    logic             w_v_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic [SLICE-1:0] w_slice  [STAGES];
    logic             w_co     [STAGES];
    logic             w_cmsb   [STAGES];
    logic             w_adv;

    assign w_adv     = ~r_valid[STAGES-1] | out_ready;
    assign in_ready  = w_adv | ~rst_n;
    assign out_valid = r_valid[STAGES-1] & rst_n;
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_a_in[k]   = a;
            assign w_b_in[k]   = (mode == MODE_SUB) ? ~b : b;
            assign w_sum_in[k] = '0;
            assign w_v_in[k]   = in_valid;
            assign w_c_in[k]   = cin;
        end else begin : g_body
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_sum_in[k] = r_sum[k-1];
            assign w_v_in[k]   = r_valid[k-1];
            assign w_c_in[k]   = r_carry[k-1];
        end

        add_slice #(
            .SLICE_W (SLICE)
        ) u_add (
            .i_a     (w_a_in[k][SLICE-1:0]),
            .i_b     (w_b_in[k][SLICE-1:0]),
            .i_ci    (w_c_in[k]),
            .o_s     (w_slice[k]),
            .o_co    (w_co[k]),
            .o_c_msb (w_cmsb[k])
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
            end else if (w_adv) begin
                r_valid[k] <= w_v_in[k];
                r_carry[k] <= w_co[k];
                r_a[k]     <= w_a_in[k] >> SLICE;
                r_b[k]     <= w_b_in[k] >> SLICE;
                r_sum[k]   <= (w_sum_in[k] >> SLICE) | (WIDTH'(w_slice[k]) << (WIDTH - SLICE));
            end
        end

        if (k == STAGES - 1) begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_co[k] ^ w_cmsb[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder at WIDTH=8, STAGES=2.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic im);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        exp_t         e;
        bb   = im ? ~ib : ib;
        full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, ic};
        low  = {1'b0, ia[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, ic};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = full[W] ^ low[W-1];
        return e;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every visible result must match the queue head
    // (also while stalled); the head is retired on a completed handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out: observed out_valid=1 with empty queue, required out_valid=0");
            end
            if (sbq.size() != 0) begin
                checks++;
                assert ({sum, cout, ovf} === sbq[0]) else begin
                    errors++;
                    $error("FAIL result: observed sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                           sum, cout, ovf, sbq[0].s, sbq[0].c, sbq[0].v);
                end
                if (out_ready === 1'b1) void'(sbq.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic im, input logic ordy,
                         input exp_t e, output logic acc);
        in_valid  = v;
        a         = ia;
        b         = ib;
        cin       = ic;
        mode      = im;
        out_ready = ordy;
        @(negedge clk);
        acc = v & in_ready & rst_n;
        if (acc) sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic im);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++)
            drive(1'b1, ia, ib, ic, im, 1'b1, model(ia, ib, ic, im), acc);
        chk_bit({tag, "_accepted"}, acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic beat_lat(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic im, input exp_t e);
        logic acc;
        drive(1'b1, ia, ib, ic, im, 1'b1, e, acc);
        chk_bit({tag, "_acc"}, acc, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk_bit({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_bit({tag, "_lat2"}, out_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sbq.size() != 0; n++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        chk_word({tag, "_queue_empty"}, sbq.size(), 0);
        @(negedge clk);
        chk_bit({tag, "_no_extra"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] sa [6];
        logic [W-1:0] sb [6];
        logic         acc;
        logic         v;
        logic         ordy;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rm;
        int           acc_cnt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        mode      = MODE_ADD;

        // Reset state, before and after reset edges
        #1;
        chk_bit("rst_pre_out_valid", out_valid, 1'b0);
        chk_bit("rst_pre_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_word("rst_sum", int'(sum), 0);
        chk_bit("rst_cout", cout, 1'b0);
        chk_bit("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed boundary cases with exact latency
        beat_lat("add_ff_01", 8'hFF, 8'h01, 1'b0, MODE_ADD, {8'h00, 1'b1, 1'b0});
        beat_lat("sub_80_01", 8'h80, 8'h01, 1'b1, MODE_SUB, {8'h7F, 1'b1, 1'b1});
        beat_lat("sub_01_02", 8'h01, 8'h02, 1'b1, MODE_SUB, {8'hFF, 1'b0, 1'b0});
        beat_lat("add_7f_00", 8'h7F, 8'h00, 1'b1, MODE_ADD, {8'h80, 1'b0, 1'b1});

        // Six-beat stream with a three-cycle output stall in the middle
        for (int i = 0; i < 6; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
        end
        for (int i = 0; i < 3; i++) send("stream_pre", sa[i], sb[i], i[0], MODE_ADD);
        in_valid  = 1'b1;
        a         = sa[3];
        b         = sb[3];
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit("stall_in_ready", in_ready, 1'b0);
            chk_bit("stall_out_valid", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        for (int i = 3; i < 6; i++) send("stream_post", sa[i], sb[i], i[0], MODE_SUB);
        drain("stream");

        // Reset with two beats in flight
        drive(1'b1, 8'h11, 8'h22, 1'b0, MODE_ADD, 1'b0, model(8'h11, 8'h22, 1'b0, MODE_ADD), acc);
        chk_bit("flight1_acc", acc, 1'b1);
        drive(1'b1, 8'h33, 8'h44, 1'b0, MODE_ADD, 1'b0, model(8'h33, 8'h44, 1'b0, MODE_ADD), acc);
        chk_bit("flight2_acc", acc, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_bit("postrst_quiet", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        beat_lat("postrst_beat", 8'h5A, 8'h3C, 1'b1, MODE_SUB, model(8'h5A, 8'h3C, 1'b1, MODE_SUB));

        // Random regression with random backpressure and bubbles
        acc_cnt = 0;
        for (int it = 0; it < 40000 && acc_cnt < 10000; it++) begin
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 70);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rm   = 1'($urandom);
            drive(v, ra, rb, rc, rm, ordy, model(ra, rb, rc, rm), acc);
            if (acc) acc_cnt++;
        end
        chk_word("rand_beats", acc_cnt, 10000);
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32; operand and result width in bits.
REQ-002 Parameter STAGES, default 4; number of register stages; WIDTH SHALL be an integer multiple of STAGES, and SLICE = WIDTH/STAGES bits are added per stage.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in; in subtract mode it is the not-borrow input.
REQ-009 mode  input  1  0 = add (a + b + cin); 1 = subtract (a + ~b + cin).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-014 ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Function
REQ-015 Stage k (0..STAGES-1) SHALL add operand bits [k*SLICE +: SLICE] plus the carry registered by stage k-1; stage 0 SHALL use cin.
REQ-016 Operand slices above stage k SHALL be delayed by skew registers so each slice meets its carry; completed sum slices SHALL be delayed by de-skew registers so all of sum appears in the same cycle.
REQ-017 The mode bit SHALL be applied at input (b inverted before stage 0); results SHALL be bit-exact to the reference expressions in REQ-009 for all operands.
REQ-018 Each stage SHALL carry a valid bit; advance = ~out_valid | out_ready; in_ready = advance.
REQ-019 When advance = 1, all stages SHALL shift one position together; when advance = 0, all stage registers SHALL hold.
REQ-020 A beat SHALL be accepted when in_valid & in_ready; if in_valid = 0 while advancing, a bubble (valid = 0) SHALL enter stage 0.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be one beat per cycle.
REQ-022 Bubbles SHALL NOT be collapsed during a stall.
REQ-023 Beats SHALL leave in acceptance order, with none lost or duplicated.
REQ-024 sum, cout and ovf SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-025 Data fields of a bubble are don't-care; out_valid SHALL be 0 for bubbles.
REQ-026 STAGES = 1 SHALL degenerate to a single registered WIDTH-bit add with latency 1.

Reset
REQ-027 While rst_n = 0 at a clock edge, all stage valid bits, carry registers, skew/de-skew registers, sum, cout and ovf SHALL become 0.
REQ-028 While rst_n = 0, out_valid = 0 and in_ready = 1.
REQ-029 Reset asserted mid-operation SHALL discard every in-flight beat; no result from before reset SHALL appear afterwards.
REQ-030 The first beat accepted after reset deasserts SHALL appear after exactly STAGES cycles.

Structure
REQ-031 A shared package pipe_adder_pkg SHALL hold the mode encodings MODE_ADD = 0 and MODE_SUB = 1.
REQ-032 One sub-module, add_slice (SLICE-bit ripple adder built by a generate loop of one-bit full adders, with carry-out and MSB carry-in outputs), SHALL be instantiated STAGES times via generate.
REQ-033 Only the last stage's add_slice MSB carry-in SHALL feed ovf.

Verification (WIDTH=8, STAGES=2)
REQ-034 Add 0xFF + 0x01, cin=0, out_ready=1 -> 2 cycles later: sum=0x00, cout=1, ovf=0.
REQ-035 Subtract 0x80 - 0x01, cin=1 -> sum=0x7F, cout=1, ovf=1; subtract 0x01 - 0x02, cin=1 -> sum=0xFF, cout=0, ovf=0.
REQ-036 Add 0x7F + 0x00, cin=1 -> sum=0x80, ovf=1, cout=0.
REQ-037 Stream of 6 back-to-back beats with out_ready held low for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 6 results correct and in order.
REQ-038 rst_n pulsed low one cycle with 2 beats in flight -> out_valid=0 next cycle, neither result ever emitted, and a new beat's result appears 2 cycles after acceptance.
REQ-039 Random regression of 10k beats with random in_valid/out_ready against the reference model -> zero mismatches.
